// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core / DMA requesters, the data-memory arbiter and the data memory.
// Handshake: a request transfers on a posedge where valid=1 and ready=1; the requester holds valid/we/addr/wdata stable until then.
interface dmem_arbiter_if;
  logic        core_valid;
  logic        core_we;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic        core_ready;
  logic        core_rvalid;
  logic [63:0] core_rdata;

  logic        dma_valid;
  logic        dma_we;
  logic [63:0] dma_addr;
  logic [63:0] dma_wdata;
  logic        dma_ready;
  logic        dma_rvalid;
  logic [63:0] dma_rdata;

  logic        err;
  logic        err_src;

  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  core_valid, core_we, core_addr, core_wdata,
    output core_ready, core_rvalid, core_rdata,
    input  dma_valid, dma_we, dma_addr, dma_wdata,
    output dma_ready, dma_rvalid, dma_rdata,
    output err, err_src,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_valid, core_we, core_addr, core_wdata,
    input  core_ready, core_rvalid, core_rdata,
    output dma_valid, dma_we, dma_addr, dma_wdata,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  err, err_src,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core has priority, a DMA request stalled MAX_WAIT cycles is forced ahead.
// Loads return one cycle after accept; out-of-range accesses are accepted, suppressed and flagged on err.
module dmem_arbiter #(
  parameter int DEPTH    = 64,
  parameter int MAX_WAIT = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int              WW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [63:0]     DEPTH64  = 64'(DEPTH);

  logic [WW-1:0] wait_cnt;
  logic          force_dma;
  logic          grant_core;
  logic          grant_dma;
  logic          grant;
  logic          sel_we;
  logic [63:0]   sel_addr;
  logic [63:0]   sel_wdata;
  logic          in_range;

  logic          core_rvalid_q;
  logic [63:0]   core_rdata_q;
  logic          dma_rvalid_q;
  logic [63:0]   dma_rdata_q;
  logic          err_q;
  logic          err_src_q;

  always_comb begin
    force_dma  = bus.dma_valid && (wait_cnt == WAIT_MAX);
    grant_core = !rst && bus.core_valid && !force_dma;
    grant_dma  = !rst && bus.dma_valid && !grant_core;
    grant      = grant_core || grant_dma;
    sel_we     = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    if (grant_core) begin
      sel_we    = bus.core_we;
      sel_addr  = bus.core_addr;
      sel_wdata = bus.core_wdata;
    end else if (grant_dma) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end
    // Full 64-bit compare: high address bits must never alias into the array.
    in_range = sel_addr < DEPTH64;
  end

  assign bus.core_ready  = grant_core;
  assign bus.dma_ready   = grant_dma;
  assign bus.mem_read    = grant && !sel_we && in_range;
  assign bus.mem_write   = grant && sel_we && in_range;
  assign bus.mem_addr    = sel_addr;
  assign bus.mem_wdata   = sel_wdata;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.dma_rvalid  = dma_rvalid_q;
  assign bus.dma_rdata   = dma_rdata_q;
  assign bus.err         = err_q;
  assign bus.err_src     = err_src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      core_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      dma_rvalid_q  <= 1'b0;
      dma_rdata_q   <= '0;
      err_q         <= 1'b0;
      err_src_q     <= 1'b0;
    end else begin
      if (!bus.dma_valid || grant_dma) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WW'(1);
      end

      core_rvalid_q <= grant_core && !sel_we;
      dma_rvalid_q  <= grant_dma && !sel_we;
      // Out-of-range loads still complete, returning zero instead of memory data.
      if (grant_core && !sel_we) core_rdata_q <= in_range ? bus.mem_rdata : '0;
      if (grant_dma && !sel_we)  dma_rdata_q  <= in_range ? bus.mem_rdata : '0;

      err_q     <= grant && !in_range;
      err_src_q <= grant_dma && !in_range;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of per-cycle request vectors with expected grants/strobes/errors,
// load data checked through per-port expected queues, plus hand-written reset and stall sequences.
module tb_dmem_arbiter;
  logic clk;
  logic rst;
  logic mem_clear;

  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH(64), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: synchronous write, combinational read, zero outside the array.
  logic [63:0] tb_mem [0:63];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 64'h0;
    end else if (bus.mem_write) begin
      tb_mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = (bus.mem_addr < 64'd64) ? tb_mem[bus.mem_addr[5:0]] : 64'h0;

  typedef struct {
    bit          cv;
    bit          cw;
    logic [63:0] ca;
    logic [63:0] cd;
    bit          dv;
    bit          dw;
    logic [63:0] da;
    logic [63:0] dd;
    bit          e_cr;
    bit          e_dr;
    bit          e_rd;
    bit          e_wr;
    bit          e_err;
    bit          e_src;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] core_q[$];
  logic [63:0] dma_q[$];
  logic [63:0] last_core;
  logic [63:0] last_dma;
  int          checks;
  int          errors;

  localparam logic [63:0] A_BIG = 64'h8000_0000_0000_0003;

  function automatic vec_t mk(bit cv, bit cw, logic [63:0] ca, logic [63:0] cd,
                              bit dv, bit dw, logic [63:0] da, logic [63:0] dd,
                              bit e_cr, bit e_dr, bit e_rd, bit e_wr,
                              bit e_err, bit e_src, logic [63:0] e_rdata);
    vec_t v;
    v.cv = cv; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dv = dv; v.dw = dw; v.da = da; v.dd = dd;
    v.e_cr = e_cr; v.e_dr = e_dr; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_err = e_err; v.e_src = e_src; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.core_valid = v.cv; bus.core_we = v.cw; bus.core_addr = v.ca; bus.core_wdata = v.cd;
    bus.dma_valid  = v.dv; bus.dma_we  = v.dw; bus.dma_addr  = v.da; bus.dma_wdata  = v.dd;
  endtask

  task automatic check_responses(input string tag);
    logic [63:0] e;
    if (core_q.size() > 0) begin
      e = core_q.pop_front();
      check({tag, " core_rvalid"}, 64'(bus.core_rvalid), 64'd1);
      check({tag, " core_rdata"}, bus.core_rdata, e);
      last_core = e;
    end else begin
      check({tag, " core_rvalid"}, 64'(bus.core_rvalid), 64'd0);
      check({tag, " core_rdata hold"}, bus.core_rdata, last_core);
    end
    if (dma_q.size() > 0) begin
      e = dma_q.pop_front();
      check({tag, " dma_rvalid"}, 64'(bus.dma_rvalid), 64'd1);
      check({tag, " dma_rdata"}, bus.dma_rdata, e);
      last_dma = e;
    end else begin
      check({tag, " dma_rvalid"}, 64'(bus.dma_rvalid), 64'd0);
      check({tag, " dma_rdata hold"}, bus.dma_rdata, last_dma);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    string       tag;
    logic [63:0] e_addr;
    logic [63:0] e_wdata;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v);
    #1;
    e_addr  = v.e_cr ? v.ca : (v.e_dr ? v.da : 64'h0);
    e_wdata = v.e_cr ? v.cd : (v.e_dr ? v.dd : 64'h0);
    check({tag, " core_ready"}, 64'(bus.core_ready), 64'(v.e_cr));
    check({tag, " dma_ready"}, 64'(bus.dma_ready), 64'(v.e_dr));
    check({tag, " mem_read"}, 64'(bus.mem_read), 64'(v.e_rd));
    check({tag, " mem_write"}, 64'(bus.mem_write), 64'(v.e_wr));
    check({tag, " mem_addr"}, bus.mem_addr, e_addr);
    check({tag, " mem_wdata"}, bus.mem_wdata, e_wdata);
    if (v.e_cr && !v.cw) core_q.push_back(v.e_rdata);
    if (v.e_dr && !v.dw) dma_q.push_back(v.e_rdata);
    @(posedge clk);
    #1;
    check({tag, " err"}, 64'(bus.err), 64'(v.e_err));
    if (v.e_err) check({tag, " err_src"}, 64'(bus.err_src), 64'(v.e_src));
    check_responses(tag);
  endtask

  vec_t idle_v, both_v, force_v, core_l5_v;
  int   n;

  initial begin
    checks = 0; errors = 0; n = 0;
    last_core = 64'h0; last_dma = 64'h0;
    idle_v    = mk(0,0,0,0,            0,0,0,0,   0,0,0,0, 0,0, 0);
    both_v    = mk(1,0,5,0,            1,0,10,0,  1,0,1,0, 0,0, 64'hDEAD_BEEF);
    force_v   = mk(1,0,5,0,            1,0,10,0,  0,1,1,0, 0,0, 64'h1234);
    core_l5_v = mk(1,0,5,0,            0,0,0,0,   1,0,1,0, 0,0, 64'hDEAD_BEEF);

    // Directed accesses, range boundaries and error reporting.
    vecs.push_back(mk(1,1,5,64'hDEAD_BEEF, 0,0,0,0,      1,0,0,1, 0,0, 0));
    vecs.push_back(core_l5_v);
    vecs.push_back(idle_v);
    vecs.push_back(mk(0,0,0,0,            1,1,10,64'h1234, 0,1,0,1, 0,0, 0));
    vecs.push_back(mk(1,0,10,0,           0,0,0,0,      1,0,1,0, 0,0, 64'h1234));
    vecs.push_back(mk(0,0,0,0,            1,0,64,0,     0,1,0,0, 1,1, 0));
    vecs.push_back(mk(1,0,A_BIG,0,        0,0,0,0,      1,0,0,0, 1,0, 0));
    vecs.push_back(mk(1,1,63,64'hAAAA,    0,0,0,0,      1,0,0,1, 0,0, 0));
    vecs.push_back(mk(0,0,0,0,            1,0,63,0,     0,1,1,0, 0,0, 64'hAAAA));
    vecs.push_back(mk(1,1,64,64'h5555,    0,0,0,0,      1,0,0,0, 1,0, 0));
    vecs.push_back(mk(1,0,0,0,            0,0,0,0,      1,0,1,0, 0,0, 0));
    vecs.push_back(mk(0,0,0,0,            1,1,A_BIG,64'h9, 0,1,0,0, 1,1, 0));
    // Continuous contention: four stalls, forced DMA grant, core priority resumes.
    for (int i = 0; i < 4; i++) vecs.push_back(both_v);
    vecs.push_back(force_v);
    vecs.push_back(both_v);
    vecs.push_back(mk(0,0,0,0,            1,0,63,0,     0,1,1,0, 0,0, 64'hAAAA));
    // Dropping dma_valid clears the wait count.
    for (int i = 0; i < 3; i++) vecs.push_back(both_v);
    vecs.push_back(core_l5_v);
    for (int i = 0; i < 4; i++) vecs.push_back(both_v);
    vecs.push_back(force_v);

    // Reset: outputs idle, a request during reset is neither accepted nor written.
    rst = 1'b1; mem_clear = 1'b1;
    drive(idle_v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(mk(1,1,3,64'h77, 1,0,4,0, 0,0,0,0, 0,0, 0));
    #1;
    check("rst core_ready", 64'(bus.core_ready), 64'd0);
    check("rst dma_ready", 64'(bus.dma_ready), 64'd0);
    check("rst mem_write", 64'(bus.mem_write), 64'd0);
    check("rst mem_read", 64'(bus.mem_read), 64'd0);
    @(posedge clk);
    #1;
    check("rst err", 64'(bus.err), 64'd0);
    check("rst err_src", 64'(bus.err_src), 64'd0);
    check_responses("rst");
    @(negedge clk);
    rst = 1'b0; mem_clear = 1'b0;
    drive(idle_v);

    foreach (vecs[i]) begin
      apply(n, vecs[i]);
      n++;
    end

    // Load accepted, then reset rises: the load response is cancelled and wait_cnt cleared.
    apply(n, both_v); n++;
    apply(n, both_v); n++;
    @(negedge clk);
    drive(both_v);
    #1;
    check("pre-rst core_ready", 64'(bus.core_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(mk(1,1,20,64'h55, 1,1,21,64'h66, 0,0,0,0, 0,0, 0));
    #1;
    check("rst2 core_ready", 64'(bus.core_ready), 64'd0);
    check("rst2 dma_ready", 64'(bus.dma_ready), 64'd0);
    check("rst2 mem_write", 64'(bus.mem_write), 64'd0);
    check("rst2 mem_read", 64'(bus.mem_read), 64'd0);
    @(posedge clk);
    #1;
    last_core = 64'h0; last_dma = 64'h0;
    check("rst2 err", 64'(bus.err), 64'd0);
    check("rst2 err_src", 64'(bus.err_src), 64'd0);
    check_responses("rst2");
    @(negedge clk);
    rst = 1'b0;
    drive(idle_v);
    for (int i = 0; i < 4; i++) begin
      apply(n, both_v); n++;
    end
    apply(n, force_v); n++;
    apply(n, mk(1,0,20,0, 0,0,0,0, 1,0,1,0, 0,0, 0)); n++;
    apply(n, mk(0,0,0,0, 1,0,21,0, 0,1,1,0, 0,0, 0)); n++;
    apply(n, idle_v); n++;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 64: number of 64-bit words in the data memory; legal word addresses are 0..DEPTH-1.
REQ-002 Parameter MAX_WAIT, default 4: cycles a stalled DMA request waits before it is forced ahead of the core.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 core_valid  input  1  core MEM-stage access request.
REQ-006 core_we  input  1  1 = store, 0 = load.
REQ-007 core_addr  input  64  word address.
REQ-008 core_wdata  input  64  store data.
REQ-009 core_ready  output  1  core request accepted this cycle (combinational).
REQ-010 core_rvalid  output  1  core load data valid (registered).
REQ-011 core_rdata  output  64  core load data.
REQ-012 dma_valid, dma_we, dma_addr[63:0], dma_wdata[63:0]  input  same meanings as the core_* inputs, for the DMA/loader port.
REQ-013 dma_ready, dma_rvalid, dma_rdata[63:0]  output  same meanings as the core_* outputs, for the DMA port.
REQ-014 err  output  1  one-cycle pulse: the previous accepted access was out of range.
REQ-015 err_src  output  1  requester of the erroring access (0 = core, 1 = DMA); valid when err=1.
REQ-016 mem_read  output  1  drives the data memory MemRead.
REQ-017 mem_write  output  1  drives the data memory MemWrite.
REQ-018 mem_addr  output  64  drives the data memory addr.
REQ-019 mem_wdata  output  64  drives the data memory write_data.
REQ-020 mem_rdata  input  64  from the data memory read_data (combinational read).

Function
REQ-021 Accept at most one request per cycle; the accepted requester alone sees ready=1.
REQ-022 Default priority is core over DMA.
REQ-023 wait_cnt (0..MAX_WAIT, saturating) increments each cycle that dma_valid=1 and dma_ready=0.
REQ-024 wait_cnt clears on a DMA accept or whenever dma_valid=0.
REQ-025 When wait_cnt==MAX_WAIT and dma_valid=1, grant DMA even if core_valid=1; core_ready=0 that cycle.
REQ-026 Drive mem_addr/mem_wdata from the granted requester; with no grant, mem_addr=0 and mem_wdata=0.
REQ-027 mem_read = grant & !we & in_range; mem_write = grant & we & in_range, where in_range = (addr < DEPTH) with a full 64-bit compare.
REQ-028 Store: the memory write commits at the same posedge as the accept; there is no response pulse.
REQ-029 Load: at the accept posedge, register mem_rdata into the granted port's rdata; that port's rvalid=1 for exactly the following cycle (latency 1).
REQ-030 Out-of-range access: accepted (ready=1), both memory strobes 0, err=1 and err_src set for the next cycle.
REQ-031 Out-of-range load: the port's rvalid also pulses, with rdata=0.
REQ-032 The non-granted port's rdata holds its last value and its rvalid=0.
REQ-033 Back-to-back accepts are allowed every cycle; rvalid may be high on consecutive cycles.
REQ-034 A requester holds valid/we/addr/wdata stable until it sees ready; the arbiter does not buffer un-accepted requests.
REQ-035 Simultaneous core and DMA requests with wait_cnt<MAX_WAIT: core accepted, DMA stalls, wait_cnt+1.
REQ-036 After a forced DMA grant, wait_cnt returns to 0 and core priority resumes next cycle.

Reset
REQ-037 While rst=1 at a posedge: wait_cnt=0, core_rvalid=dma_rvalid=0, core_rdata=dma_rdata=0, err=0, err_src=0.
REQ-038 While rst=1: core_ready=dma_ready=0, mem_read=mem_write=0; no memory write occurs that cycle.
REQ-039 A load accepted in the cycle before rst rises produces no rvalid pulse after reset.
REQ-040 Operation resumes on the first cycle with rst=0.

Verification
REQ-041 Core store addr=5, wdata=0xDEAD_BEEF, then core load addr=5 -> core_ready=1 both cycles; core_rvalid=1 one cycle after the load; core_rdata=0xDEADBEEF.
REQ-042 Core and DMA both valid continuously, MAX_WAIT=4 -> DMA stalls 4 cycles; DMA accepted in cycle 5 with core_ready=0; core accepted again in cycle 6.
REQ-043 DMA load addr=64 (DEPTH=64) -> dma_ready=1, mem_read=0; next cycle err=1, err_src=1, dma_rvalid=1, dma_rdata=0.
REQ-044 DMA store addr=10, wdata=0x1234; next cycle core load addr=10 -> core_rdata=0x1234, dma_rvalid never asserted.
REQ-045 Core load issued, rst=1 the next cycle -> core_rvalid=0 and all outputs at reset values; wait_cnt=0 afterwards.
REQ-046 Address 0x8000_0000_0000_0003 -> treated as out of range (full-width compare), no memory strobe, err pulse.
